// File: rtl/reg_transfer_ctrl.sv
// Strobe sequencer for the A/X/Y/S register group: runs the transfer and
// load-immediate opcodes as DECODE -> DRIVE -> LATCH -> FIN, or DECODE -> ERR.
module reg_transfer_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] OPCODE,
    input  logic [7:0] OPERAND,
    output logic       A_LOAD,
    output logic       X_LOAD,
    output logic       Y_LOAD,
    output logic       S_LOAD,
    output logic       A_BE,
    output logic       X_BE,
    output logic       Y_BE,
    output logic       S_BE,
    output logic       IMM_BE,
    output logic [7:0] IMM_DATA,
    output logic       FLAG_LOAD,
    output logic       BUSY,
    output logic       DONE,
    output logic       ILLEGAL
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_FIN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // Source one-hot order {IMM,S,Y,X,A}; destination order {S,Y,X,A}.
    localparam logic [4:0] SRC_A   = 5'b00001;
    localparam logic [4:0] SRC_X   = 5'b00010;
    localparam logic [4:0] SRC_Y   = 5'b00100;
    localparam logic [4:0] SRC_S   = 5'b01000;
    localparam logic [4:0] SRC_IMM = 5'b10000;
    localparam logic [3:0] DST_A   = 4'b0001;
    localparam logic [3:0] DST_X   = 4'b0010;
    localparam logic [3:0] DST_Y   = 4'b0100;
    localparam logic [3:0] DST_S   = 4'b1000;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] imm_q, imm_d;

    logic [4:0] be_q, be_d;
    logic [3:0] load_q, load_d;
    logic       flag_q, flag_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    logic       op_legal;
    logic [4:0] op_src;
    logic [3:0] op_dst;
    logic       op_flag;

    always_comb begin
        op_legal = 1'b1;
        op_src   = 5'b0;
        op_dst   = 4'b0;
        op_flag  = 1'b1;
        case (opcode_q)
            8'hAA: begin op_src = SRC_A;   op_dst = DST_X; end
            8'hA8: begin op_src = SRC_A;   op_dst = DST_Y; end
            8'h8A: begin op_src = SRC_X;   op_dst = DST_A; end
            8'h98: begin op_src = SRC_Y;   op_dst = DST_A; end
            8'hBA: begin op_src = SRC_S;   op_dst = DST_X; end
            8'h9A: begin op_src = SRC_X;   op_dst = DST_S; op_flag = 1'b0; end
            8'hA9: begin op_src = SRC_IMM; op_dst = DST_A; end
            8'hA2: begin op_src = SRC_IMM; op_dst = DST_X; end
            8'hA0: begin op_src = SRC_IMM; op_dst = DST_Y; end
            default: begin
                op_legal = 1'b0;
                op_flag  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        imm_d    = imm_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    opcode_d = OPCODE;
                    imm_d    = OPERAND;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = op_legal ? ST_DRIVE : ST_ERR;
            ST_DRIVE:  state_d = ST_LATCH;
            ST_LATCH:  state_d = ST_FIN;
            ST_FIN:    state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered strobes
    // line up with the state they belong to. The opcode is stable whenever
    // the upcoming state is DRIVE or LATCH, so opcode_q is sufficient here.
    always_comb begin
        busy_d    = (state_d == ST_DECODE) || (state_d == ST_DRIVE) || (state_d == ST_LATCH);
        be_d      = ((state_d == ST_DRIVE) || (state_d == ST_LATCH)) ? op_src : 5'b0;
        load_d    = (state_d == ST_LATCH) ? op_dst : 4'b0;
        flag_d    = (state_d == ST_LATCH) && op_flag;
        done_d    = (state_d == ST_FIN);
        illegal_d = (state_d == ST_ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 8'h00;
            imm_q     <= 8'h00;
            be_q      <= 5'b0;
            load_q    <= 4'b0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            imm_q     <= imm_d;
            be_q      <= be_d;
            load_q    <= load_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign A_BE      = be_q[0];
    assign X_BE      = be_q[1];
    assign Y_BE      = be_q[2];
    assign S_BE      = be_q[3];
    assign IMM_BE    = be_q[4];
    assign A_LOAD    = load_q[0];
    assign X_LOAD    = load_q[1];
    assign Y_LOAD    = load_q[2];
    assign S_LOAD    = load_q[3];
    assign FLAG_LOAD = flag_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ILLEGAL   = illegal_q;
    assign IMM_DATA  = imm_q;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Bench for reg_transfer_ctrl: a per-transaction timeline model checked every
// cycle, plus directed literal checks on the scenarios of interest.
module tb_reg_transfer_ctrl;

    logic       clk = 1'b0;
    logic       RST, START;
    logic [7:0] OPCODE, OPERAND;
    logic       A_LOAD, X_LOAD, Y_LOAD, S_LOAD;
    logic       A_BE, X_BE, Y_BE, S_BE, IMM_BE;
    logic [7:0] IMM_DATA;
    logic       FLAG_LOAD, BUSY, DONE, ILLEGAL;

    int checks   = 0;
    int failures = 0;

    reg_transfer_ctrl dut (
        .CLK(clk), .RST(RST), .START(START), .OPCODE(OPCODE), .OPERAND(OPERAND),
        .A_LOAD(A_LOAD), .X_LOAD(X_LOAD), .Y_LOAD(Y_LOAD), .S_LOAD(S_LOAD),
        .A_BE(A_BE), .X_BE(X_BE), .Y_BE(Y_BE), .S_BE(S_BE), .IMM_BE(IMM_BE),
        .IMM_DATA(IMM_DATA), .FLAG_LOAD(FLAG_LOAD), .BUSY(BUSY), .DONE(DONE),
        .ILLEGAL(ILLEGAL)
    );

    always #5 clk = ~clk;

    // be order {IMM,S,Y,X,A}; ld order {S,Y,X,A}
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       illegal;
        logic [4:0] be;
        logic [3:0] ld;
        logic       flag;
        logic [7:0] imm;
    } obs_t;

    obs_t sched_q[$];
    obs_t exp_obs;
    obs_t act_obs;
    logic [7:0] model_imm;
    logic model_valid = 1'b0;

    function automatic void lookup(input logic [7:0] op, output logic legal,
                                   output logic [4:0] src, output logic [3:0] dst,
                                   output logic fl);
        legal = 1'b1; fl = 1'b1; src = 5'b0; dst = 4'b0;
        case (op)
            8'hAA: begin src = 5'b00001; dst = 4'b0010; end
            8'hA8: begin src = 5'b00001; dst = 4'b0100; end
            8'h8A: begin src = 5'b00010; dst = 4'b0001; end
            8'h98: begin src = 5'b00100; dst = 4'b0001; end
            8'hBA: begin src = 5'b01000; dst = 4'b0010; end
            8'h9A: begin src = 5'b00010; dst = 4'b1000; fl = 1'b0; end
            8'hA9: begin src = 5'b10000; dst = 4'b0001; end
            8'hA2: begin src = 5'b10000; dst = 4'b0010; end
            8'hA0: begin src = 5'b10000; dst = 4'b0100; end
            default: begin legal = 1'b0; fl = 1'b0; end
        endcase
    endfunction

    // Model: an accepted START expands into the full cycle-by-cycle output
    // timeline of that instruction; while a timeline is pending, START is ignored.
    initial begin
        obs_t e;
        logic lg, fl;
        logic [4:0] s;
        logic [3:0] d;
        model_imm = 8'h00;
        forever begin
            @(posedge clk);
            if (RST) begin
                sched_q.delete();
                model_imm   = 8'h00;
                exp_obs     = '0;
                model_valid = 1'b1;
            end else if (sched_q.size() > 0) begin
                exp_obs = sched_q.pop_front();
            end else if (START) begin
                model_imm = OPERAND;
                lookup(OPCODE, lg, s, d, fl);
                e = '0; e.imm = model_imm; e.busy = 1'b1;
                sched_q.push_back(e);
                if (lg) begin
                    e.be = s;                 sched_q.push_back(e);
                    e.ld = d; e.flag = fl;    sched_q.push_back(e);
                    e = '0; e.imm = model_imm; e.done = 1'b1;
                    sched_q.push_back(e);
                end else begin
                    e = '0; e.imm = model_imm; e.illegal = 1'b1;
                    sched_q.push_back(e);
                end
                e = '0; e.imm = model_imm;
                sched_q.push_back(e);
                exp_obs = sched_q.pop_front();
            end else begin
                exp_obs = '0;
                exp_obs.imm = model_imm;
            end
            #1;
            if (model_valid) begin
                act_obs = {BUSY, DONE, ILLEGAL, {IMM_BE, S_BE, Y_BE, X_BE, A_BE},
                           {S_LOAD, Y_LOAD, X_LOAD, A_LOAD}, FLAG_LOAD, IMM_DATA};
                checks++;
                if (act_obs !== exp_obs) begin
                    failures++;
                    $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_obs, exp_obs);
                end
                checks++;
                if (($countones(act_obs.be) > 1) || ($countones(act_obs.ld) > 1) ||
                    ((act_obs.ld != 4'b0) && (act_obs.be == 5'b0))) begin
                    failures++;
                    $display("FAIL invariant t=%0t actual be=%b ld=%b required onehot0 and ld=>be",
                             $time, act_obs.be, act_obs.ld);
                end
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic any_strobe();
        return A_LOAD | X_LOAD | Y_LOAD | S_LOAD | A_BE | X_BE | Y_BE | S_BE | IMM_BE | FLAG_LOAD;
    endfunction

    // Present a START for one edge; afterwards scramble OPCODE/OPERAND to
    // show later changes are ignored. Returns in the DECODE cycle.
    task automatic start_op(input logic [7:0] op, input logic [7:0] operand);
        START = 1'b1; OPCODE = op; OPERAND = operand;
        @(negedge clk);
        START = 1'b0; OPCODE = 8'hEA; OPERAND = 8'h13;
        $display("txn op=%h operand=%h accepted t=%0t", op, operand, $time);
    endtask

    initial begin
        RST = 1'b1; START = 1'b1; OPCODE = 8'hAA; OPERAND = 8'h5A;
        @(negedge clk); @(negedge clk);
        chk1("reset_busy", BUSY, 1'b0);
        chk8("reset_imm", IMM_DATA, 8'h00);
        chk1("reset_strobes", any_strobe(), 1'b0);
        RST = 1'b0; START = 1'b0;
        @(negedge clk);
        chk1("post_reset_strobes", any_strobe() | DONE | ILLEGAL, 1'b0);

        // LDX #AA
        start_op(8'hA2, 8'hAA);
        chk1("ldx_decode_busy", BUSY, 1'b1);
        chk8("ldx_imm_data", IMM_DATA, 8'hAA);
        chk1("ldx_decode_imm_be", IMM_BE, 1'b0);
        @(negedge clk);
        chk1("ldx_drive_imm_be", IMM_BE, 1'b1);
        chk1("ldx_drive_x_load", X_LOAD, 1'b0);
        @(negedge clk);
        chk1("ldx_latch_x_load", X_LOAD, 1'b1);
        chk1("ldx_latch_flag", FLAG_LOAD, 1'b1);
        @(negedge clk);
        chk1("ldx_fin_done", DONE, 1'b1);
        chk1("ldx_fin_busy", BUSY, 1'b0);
        @(negedge clk);

        // TXS
        start_op(8'h9A, 8'h00);
        @(negedge clk);
        chk1("txs_drive_x_be", X_BE, 1'b1);
        @(negedge clk);
        chk1("txs_latch_x_be", X_BE, 1'b1);
        chk1("txs_latch_s_load", S_LOAD, 1'b1);
        chk1("txs_latch_flag", FLAG_LOAD, 1'b0);
        @(negedge clk);
        chk1("txs_fin_done", DONE, 1'b1);
        @(negedge clk);

        // Illegal EA
        start_op(8'hEA, 8'h77);
        chk1("ill_decode_busy", BUSY, 1'b1);
        @(negedge clk);
        chk1("ill_err_illegal", ILLEGAL, 1'b1);
        chk1("ill_err_busy", BUSY, 1'b0);
        @(negedge clk);
        chk1("ill_idle_illegal", ILLEGAL, 1'b0);
        chk8("ill_imm_data", IMM_DATA, 8'h77);

        // TAX then TYA with START held high throughout
        START = 1'b1; OPCODE = 8'hAA; OPERAND = 8'h01;
        @(negedge clk);
        OPCODE = 8'h98; OPERAND = 8'h02;
        chk1("b2b_first_busy", BUSY, 1'b1);
        @(negedge clk); @(negedge clk);
        chk1("b2b_tax_x_load", X_LOAD, 1'b1);
        @(negedge clk);
        chk1("b2b_tax_done", DONE, 1'b1);
        @(negedge clk);
        chk1("b2b_idle_gap", BUSY, 1'b0);
        @(negedge clk);
        START = 1'b0;
        chk1("b2b_second_busy", BUSY, 1'b1);
        chk8("b2b_second_imm", IMM_DATA, 8'h02);
        @(negedge clk);
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        chk1("b2b_tya_a_load", A_LOAD, 1'b1);
        chk1("b2b_tya_y_be", Y_BE, 1'b1);
        @(negedge clk);
        chk1("b2b_tya_done", DONE, 1'b1);
        @(negedge clk); @(negedge clk);

        // Reset during LATCH of LDA #55
        start_op(8'hA9, 8'h55);
        @(negedge clk); @(negedge clk);
        chk1("rst_mid_latch_a_load", A_LOAD, 1'b1);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        chk1("rst_mid_strobes", any_strobe() | DONE | ILLEGAL, 1'b0);
        chk8("rst_mid_imm", IMM_DATA, 8'h00);
        @(negedge clk);
        chk1("rst_mid_no_done", DONE, 1'b0);
        start_op(8'hA9, 8'h55);
        @(negedge clk); @(negedge clk);
        chk1("lda_again_a_load", A_LOAD, 1'b1);
        @(negedge clk);
        chk1("lda_again_done", DONE, 1'b1);
        @(negedge clk);

        // Remaining opcodes, model-checked
        begin
            logic [7:0] ops [5];
            ops[0] = 8'hA8; ops[1] = 8'h8A; ops[2] = 8'hBA; ops[3] = 8'hA0; ops[4] = 8'h00;
            for (int i = 0; i < 5; i++) begin
                start_op(ops[i], 8'h80 + 8'(i));
                repeat (5) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
